// File: rtl/pbvi_backup_seq.sv
// -----------------------------------------------------------------------------
// pbvi_backup_seq
//
// Time-multiplexed PBVI backup stage. For every belief point b and action a it
// scans the alpha vectors of each observation o, keeps the one with the largest
// dot product against belief[b] (ties keep the lowest index), accumulates the
// winners elementwise, and writes reward[a] + sum into gamma_action_belief[a][b].
// One alpha vector is examined per clock; a single write cycle closes each (b,a).
//
// Optional feature macro: PBVI_BACKUP_SAT_EN
//   defined   -> write-stage result saturates to 2^DATA_W-1
//   undefined -> write-stage result wraps modulo 2^DATA_W
//
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous reset, active-high
//   en                   start request, sampled only in IDLE
//   alpha_in             element ((a*NUM_OBS+o)*NUM_ALPHA+j)*NUM_STATES+s
//   reward_in            element a*NUM_STATES+s
//   belief_in            element b*NUM_STATES+s
//   busy                 high while the scan/write sequence is running
//   en_next              one-cycle completion pulse for the next stage
//   gamma_action_belief  element (a*NUM_BELIEF+b)*NUM_STATES+s, registered
// -----------------------------------------------------------------------------
module pbvi_backup_seq #(
    parameter int DATA_W      = 16,
    parameter int NUM_STATES  = 2,
    parameter int NUM_ACTIONS = 3,
    parameter int NUM_OBS     = 2,
    parameter int NUM_ALPHA   = 16,
    parameter int NUM_BELIEF  = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             en,
    input  logic [NUM_ACTIONS*NUM_OBS*NUM_ALPHA*NUM_STATES*DATA_W-1:0] alpha_in,
    input  logic [NUM_ACTIONS*NUM_STATES*DATA_W-1:0]         reward_in,
    input  logic [NUM_BELIEF*NUM_STATES*DATA_W-1:0]          belief_in,
    output logic                                             busy,
    output logic                                             en_next,
    output logic [NUM_ACTIONS*NUM_BELIEF*NUM_STATES*DATA_W-1:0] gamma_action_belief
);

    localparam int DOT_W = 2*DATA_W + $clog2(NUM_STATES);
    localparam int SUM_W = DATA_W + $clog2(NUM_OBS+1);
    localparam int RES_W = SUM_W + 1;
    localparam int A_W   = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;
    localparam int O_W   = (NUM_OBS > 1)     ? $clog2(NUM_OBS)     : 1;
    localparam int J_W   = (NUM_ALPHA > 1)   ? $clog2(NUM_ALPHA)   : 1;
    localparam int B_W   = (NUM_BELIEF > 1)  ? $clog2(NUM_BELIEF)  : 1;

    localparam logic [A_W-1:0] A_LAST = A_W'(NUM_ACTIONS-1);
    localparam logic [O_W-1:0] O_LAST = O_W'(NUM_OBS-1);
    localparam logic [J_W-1:0] J_LAST = J_W'(NUM_ALPHA-1);
    localparam logic [B_W-1:0] B_LAST = B_W'(NUM_BELIEF-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [A_W-1:0]        a_r;
    logic [O_W-1:0]        o_r;
    logic [J_W-1:0]        j_r;
    logic [B_W-1:0]        b_r;
    logic [DOT_W-1:0]      max_r;
    logic [J_W-1:0]        idx_r;
    logic [SUM_W-1:0]      sum_r   [NUM_STATES];
    logic                  busy_r;
    logic                  en_next_r;
    logic [NUM_ACTIONS*NUM_BELIEF*NUM_STATES*DATA_W-1:0] gamma_r;

    logic [DOT_W-1:0]      dot_s;
    logic                  take_s;
    logic [J_W-1:0]        best_idx_s;
    logic [DOT_W-1:0]      best_max_s;
    logic [DATA_W-1:0]     sel_s   [NUM_STATES];
    logic [DATA_W-1:0]     res_s   [NUM_STATES];

    // Bit offset of alpha element (a,o,j,s)
    function automatic logic [31:0] alpha_idx(input logic [31:0] a, input logic [31:0] o,
                                              input logic [31:0] j, input logic [31:0] s);
        return (((a*NUM_OBS + o)*NUM_ALPHA + j)*NUM_STATES + s)*DATA_W;
    endfunction

    // Bit offset of output element (a,b,s)
    function automatic logic [31:0] gamma_idx(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] s);
        return ((a*NUM_BELIEF + b)*NUM_STATES + s)*DATA_W;
    endfunction

    // Reduce reward+sum to the output width
    function automatic logic [DATA_W-1:0] reduce_res(input logic [RES_W-1:0] v);
`ifdef PBVI_BACKUP_SAT_EN
        return (v > RES_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    // Full-precision dot product of the current alpha against the current belief
    always_comb begin
        dot_s = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            dot_s = dot_s
                  + DOT_W'(alpha_in[alpha_idx(32'(a_r), 32'(o_r), 32'(j_r), s) +: DATA_W])
                  * DOT_W'(belief_in[(32'(b_r)*NUM_STATES + s)*DATA_W +: DATA_W]);
        end
    end

    // Running argmax; j==0 always loads, later entries need a strictly larger dot
    always_comb begin
        take_s     = (j_r == '0) || (dot_s > max_r);
        best_idx_s = take_s ? j_r   : idx_r;
        best_max_s = take_s ? dot_s : max_r;
    end

    // Winning alpha vector (final compare included) and the reduced write value
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            sel_s[s] = alpha_in[alpha_idx(32'(a_r), 32'(o_r), 32'(best_idx_s), s) +: DATA_W];
            res_s[s] = reduce_res(RES_W'(reward_in[(32'(a_r)*NUM_STATES + s)*DATA_W +: DATA_W])
                                  + RES_W'(sum_r[s]));
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = en ? ST_SCAN : ST_IDLE;
            ST_SCAN:  state_s = ((j_r == J_LAST) && (o_r == O_LAST)) ? ST_WRITE : ST_SCAN;
            ST_WRITE: state_s = ((a_r == A_LAST) && (b_r == B_LAST)) ? ST_DONE : ST_SCAN;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            en_next_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s == ST_SCAN) || (state_s == ST_WRITE);
            en_next_r <= (state_s == ST_DONE);
        end
    end

    // Counters, running max, observation sums and output storage
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            o_r     <= '0;
            j_r     <= '0;
            b_r     <= '0;
            max_r   <= '0;
            idx_r   <= '0;
            gamma_r <= '0;
            for (int s = 0; s < NUM_STATES; s++) sum_r[s] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        a_r <= '0;
                        o_r <= '0;
                        j_r <= '0;
                        b_r <= '0;
                        for (int s = 0; s < NUM_STATES; s++) sum_r[s] <= '0;
                    end
                end
                ST_SCAN: begin
                    max_r <= best_max_s;
                    idx_r <= best_idx_s;
                    if (j_r == J_LAST) begin
                        j_r <= '0;
                        for (int s = 0; s < NUM_STATES; s++) begin
                            sum_r[s] <= sum_r[s] + SUM_W'(sel_s[s]);
                        end
                        o_r <= (o_r == O_LAST) ? '0 : (o_r + O_W'(1));
                    end else begin
                        j_r <= j_r + J_W'(1);
                    end
                end
                ST_WRITE: begin
                    for (int s = 0; s < NUM_STATES; s++) begin
                        gamma_r[gamma_idx(32'(a_r), 32'(b_r), s) +: DATA_W] <= res_s[s];
                        sum_r[s] <= '0;
                    end
                    if (a_r == A_LAST) begin
                        a_r <= '0;
                        b_r <= (b_r == B_LAST) ? '0 : (b_r + B_W'(1));
                    end else begin
                        a_r <= a_r + A_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy                = busy_r;
    assign en_next             = en_next_r;
    assign gamma_action_belief = gamma_r;

endmodule

// File: tb/tb_pbvi_backup_seq.sv
// -----------------------------------------------------------------------------
// tb_pbvi_backup_seq
//
// Directed self-checking bench for pbvi_backup_seq at default parameters.
// Expected outputs come from hand-computed constants and a small behavioural
// reference of the backup computation; handshake timing is checked by cycle
// counting. Honours PBVI_BACKUP_SAT_EN for the expected write-stage reduction.
// -----------------------------------------------------------------------------
module tb_pbvi_backup_seq;

    localparam int D = 16;
    localparam int S = 2;
    localparam int A = 3;
    localparam int O = 2;
    localparam int J = 16;
    localparam int B = 16;
    localparam int N = B*A*(O*J+1);

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [A*O*J*S*D-1:0] alpha_in;
    logic [A*S*D-1:0]     reward_in;
    logic [B*S*D-1:0]     belief_in;
    logic                 busy;
    logic                 en_next;
    logic [A*B*S*D-1:0]   gamma_action_belief;

    int unsigned al [A][O][J][S];
    int unsigned rw [A][S];
    int unsigned bl [B][S];
    int unsigned exp_g [A*B*S];

    int n_assert;
    int n_fail;

    pbvi_backup_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .alpha_in            (alpha_in),
        .reward_in           (reward_in),
        .belief_in           (belief_in),
        .busy                (busy),
        .en_next             (en_next),
        .gamma_action_belief (gamma_action_belief)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [D-1:0] get_g(input int a, input int b, input int s);
        return gamma_action_belief[((a*B+b)*S+s)*D +: D];
    endfunction

    task automatic clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++)
            for (int j = 0; j < J; j++) for (int s = 0; s < S; s++) al[a][o][j][s] = 0;
        for (int a = 0; a < A; a++) for (int s = 0; s < S; s++) rw[a][s] = 0;
        for (int b = 0; b < B; b++) for (int s = 0; s < S; s++) bl[b][s] = 0;
    endtask

    // Drive the flat buses from the model arrays and compute expected outputs
    task automatic apply_and_model();
        longint unsigned d, bd, r;
        longint unsigned sum [S];
        int best;
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++)
            for (int j = 0; j < J; j++) for (int s = 0; s < S; s++)
                alpha_in[(((a*O+o)*J+j)*S+s)*D +: D] = 16'(al[a][o][j][s]);
        for (int a = 0; a < A; a++) for (int s = 0; s < S; s++)
            reward_in[(a*S+s)*D +: D] = 16'(rw[a][s]);
        for (int b = 0; b < B; b++) for (int s = 0; s < S; s++)
            belief_in[(b*S+s)*D +: D] = 16'(bl[b][s]);
        for (int b = 0; b < B; b++) begin
            for (int a = 0; a < A; a++) begin
                for (int s = 0; s < S; s++) sum[s] = 0;
                for (int o = 0; o < O; o++) begin
                    best = 0;
                    bd   = 0;
                    for (int j = 0; j < J; j++) begin
                        d = 0;
                        for (int s = 0; s < S; s++)
                            d += longint'(al[a][o][j][s]) * longint'(bl[b][s]);
                        if (j == 0 || d > bd) begin
                            bd   = d;
                            best = j;
                        end
                    end
                    for (int s = 0; s < S; s++) sum[s] += al[a][o][best][s];
                end
                for (int s = 0; s < S; s++) begin
                    r = rw[a][s] + sum[s];
`ifdef PBVI_BACKUP_SAT_EN
                    exp_g[(a*B+b)*S+s] = (r > 64'hFFFF) ? 32'hFFFF : 32'(r);
`else
                    exp_g[(a*B+b)*S+s] = 32'(r & 64'hFFFF);
`endif
                end
            end
        end
    endtask

    // Start one run from IDLE and check handshake timing; optional stray en pulse
    task automatic run(input string tag, input int poke_cyc);
        int cyc;
        int busy_cnt;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (en_next !== 1'b1 && cyc < 5000) begin
            if (busy === 1'b1) busy_cnt++;
            en = (cyc == poke_cyc) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(N+1));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_en_next_width"}, 64'(en_next), 64'd0);
    endtask

    task automatic check_outputs(input string tag);
        for (int a = 0; a < A; a++) for (int b = 0; b < B; b++) for (int s = 0; s < S; s++)
            chk(tag, 64'(get_g(a, b, s)), 64'(exp_g[(a*B+b)*S+s]));
    endtask

    initial begin
        int pulses;
        int first_p;
        int second_p;
        int cyc;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        en  = 1'b0;
        alpha_in  = '0;
        reward_in = '0;
        belief_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_en_next", 64'(en_next), 64'd0);
        n_assert++;
        assert (gamma_action_belief === '0) else begin
            n_fail++;
            $error("FAIL reset_gamma: observed nonzero expected all zero");
        end

        // All-equal alphas: tie everywhere, j0 wins, 2*0x1000+0x10
        clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++)
            for (int j = 0; j < J; j++) for (int s = 0; s < S; s++) al[a][o][j][s] = 32'h1000;
        for (int b = 0; b < B; b++) for (int s = 0; s < S; s++) bl[b][s] = 32'h8000;
        for (int a = 0; a < A; a++) for (int s = 0; s < S; s++) rw[a][s] = 32'h0010;
        apply_and_model();
        run("tie", 100);
        chk("tie_first", 64'(get_g(0, 0, 0)), 64'h2010);
        chk("tie_last", 64'(get_g(A-1, B-1, S-1)), 64'h2010);
        check_outputs("tie_all");

        // Equal dots at j2 and j3 with different state-1 entries; j2 must win
        clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++) begin
            al[a][o][2][0] = 32'h4000; al[a][o][2][1] = 32'h0001;
            al[a][o][3][0] = 32'h4000; al[a][o][3][1] = 32'h0002;
        end
        for (int b = 0; b < B; b++) bl[b][0] = 32'hFFFF;
        apply_and_model();
        run("tiebrk", 0);
        chk("tiebrk_s0", 64'(get_g(1, 5, 0)), 64'h8000);
        chk("tiebrk_s1", 64'(get_g(1, 5, 1)), 64'h0002);
        check_outputs("tiebrk_all");

        // Belief-dependent selection: even b picks j0, odd b picks j1
        clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++) begin
            al[a][o][0][0] = 32'hF000;
            al[a][o][1][1] = 32'hF000;
        end
        for (int b = 0; b < B; b++) bl[b][b%2] = 32'hFFFF;
        for (int a = 0; a < A; a++) begin
            rw[a][0] = 32'(a);
            rw[a][1] = 32'(2*a);
        end
        apply_and_model();
        run("belief", 0);
`ifdef PBVI_BACKUP_SAT_EN
        chk("belief_b0_s0", 64'(get_g(2, 0, 0)), 64'hFFFF);
        chk("belief_b1_s1", 64'(get_g(2, 1, 1)), 64'hFFFF);
`else
        chk("belief_b0_s0", 64'(get_g(2, 0, 0)), 64'hE002);
        chk("belief_b1_s1", 64'(get_g(2, 1, 1)), 64'hE004);
`endif
        chk("belief_b0_s1", 64'(get_g(2, 0, 1)), 64'h0004);
        chk("belief_b1_s0", 64'(get_g(2, 1, 0)), 64'h0002);
        check_outputs("belief_all");

        // Overflow: 0xFFFF + 2*0xFFFF
        clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++)
            for (int j = 0; j < J; j++) for (int s = 0; s < S; s++) al[a][o][j][s] = 32'hFFFF;
        for (int b = 0; b < B; b++) for (int s = 0; s < S; s++) bl[b][s] = 32'hFFFF;
        for (int a = 0; a < A; a++) for (int s = 0; s < S; s++) rw[a][s] = 32'hFFFF;
        apply_and_model();
        run("ovf", 0);
`ifdef PBVI_BACKUP_SAT_EN
        chk("ovf_value", 64'(get_g(1, 7, 1)), 64'hFFFF);
`else
        chk("ovf_value", 64'(get_g(1, 7, 1)), 64'hFFFD);
`endif
        check_outputs("ovf_all");

        // Reset in the middle of a run aborts it and clears the outputs
        clear_model();
        for (int a = 0; a < A; a++) for (int o = 0; o < O; o++) begin
            al[a][o][0][0] = 32'hF000;
            al[a][o][1][1] = 32'hF000;
        end
        for (int b = 0; b < B; b++) bl[b][b%2] = 32'hFFFF;
        for (int a = 0; a < A; a++) begin
            rw[a][0] = 32'(a);
            rw[a][1] = 32'(2*a);
        end
        apply_and_model();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_en_next", 64'(en_next), 64'd0);
        n_assert++;
        assert (gamma_action_belief === '0) else begin
            n_fail++;
            $error("FAIL abort_gamma: observed nonzero expected all zero");
        end
        pulses = 0;
        repeat (N+10) begin
            @(negedge clk);
            if (en_next === 1'b1) pulses++;
        end
        chk("abort_no_en_next", 64'(pulses), 64'd0);
        run("restart", 0);
        check_outputs("restart_all");

        // en held high: runs start every N+2 cycles, one pulse each
        en = 1'b1;
        @(negedge clk);
        cyc = 1;
        pulses = 0;
        first_p = 0;
        second_p = 0;
        while (cyc <= 2*N+10) begin
            if (en_next === 1'b1) begin
                pulses++;
                if (pulses == 1) first_p = cyc;
                else if (pulses == 2) second_p = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'd2);
        chk("b2b_first", 64'(first_p), 64'(N+1));
        chk("b2b_period", 64'(second_p - first_p), 64'(N+2));
        cyc = 0;
        while (en_next !== 1'b1 && cyc < 2*N) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_third_done", 64'(en_next), 64'd1);
        @(negedge clk);
        check_outputs("b2b_all");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
